ascon_data_process: RTL and testbench
=====================================

# ascon_data_process

Sequential Ascon-128 plaintext/ciphertext processing stage. It sits directly upstream of `ascon_finalization`. It loads the 320-bit state produced by the associated-data stage, after domain separation. It then absorbs 64-bit message blocks through a valid/ready handshake, emitting one output block per input block, and runs an iterative p6 permutation (one round per cycle) between non-final blocks. After the padded final block it presents the state on `x0_o..x4_o` for finalization.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  load `x*_i` into state; honoured only in IDLE
- x0_i..x4_i  in  64 each  initial state from the associated-data stage
- blk_valid  in  1  message block present
- blk_ready  out  1  block accepted when `blk_valid & blk_ready`
- blk_data  in  64  block; byte 0 in [63:56]
- blk_last  in  1  final block of message
- blk_bytes  in  3  valid bytes of final block (0..7); ignored when `blk_last=0`
- dec  in  1  decrypt select, sampled at `start` (only with ASCON_DECRYPT_EN)
- out_valid  out  1  one-cycle pulse, output block valid
- out_data  out  64  ciphertext/plaintext; invalid bytes forced to 0
- out_bytes  out  3  valid bytes in `out_data`; 0 means 8 bytes for a non-last block
- out_last  out  1  qualifies the final output block
- st_valid  out  1  one-cycle pulse, `x*_o` holds the final pre-finalization state
- x0_o..x4_o  out  64 each  state; held stable until the next `start`
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, ABSORB, PERM, DONE.
- IDLE → ABSORB on `start`. State registers load `x*_i`; mode register loads `dec`.
- ABSORB: `blk_ready=1`. On handshake, let n = `blk_last ? blk_bytes : 8`, mask(n) = top n bytes all-ones, pad(n) = bit (63-8n) set, with pad(8)=0.
  - Encrypt: x0' = x0 ^ (blk_data & mask) ^ pad(n); out_data = x0' & mask.
  - Decrypt: out_data = (x0 ^ blk_data) & mask; x0' = ((blk_data & mask) | (x0 & ~mask)) ^ pad(n).
  - x1..x4 are unchanged by absorption.
  - Not last → PERM with round counter r=6. Last → DONE.
- PERM: one Ascon round per cycle (constant addition, S-box layer, linear layer) with constant c_r = ((15-r)<<4)|r on x2. Constants for r=6..11 are 0x96, 0x87, 0x78, 0x69, 0x5a, 0x4b. After r=11 → ABSORB.
- DONE: `st_valid=1` for one cycle, then → IDLE.
- Every message ends with a block carrying `blk_last=1`. A message whose length is a multiple of 8 ends with an empty final block (`blk_bytes=0`), which absorbs the pad only.
- `start` while busy is ignored. `blk_valid` outside ABSORB is not accepted. `blk_data` bytes beyond n are ignored.
- Reset, including mid-PERM or mid-message, forces IDLE. All outputs, state and counter go to 0.

## Timing
- Handshake at cycle T: `out_valid`, `out_data`, `out_bytes` and `out_last` are registered and valid at T+1.
- Non-last block: PERM occupies T+1..T+6, `blk_ready` is low during those cycles, and the next handshake is possible at T+7 at the earliest. Throughput is 7 cycles per 64-bit block.
- Last block: DONE at T+1, with `st_valid` and `out_valid`/`out_last` both high in T+1. `x*_o` equals the padded state at T+1. IDLE at T+2, and `start` is accepted at T+2.
- start at cycle S: ABSORB from S+1, `blk_ready=1` at S+1.
- `x*_o` mirrors the state registers continuously. Finalization samples it when `st_valid=1`.

## Configuration
- `ASCON_DECRYPT_EN` defined: `dec` port present; decrypt path as above.
- Not defined: `dec` port is absent and the block is encrypt-only. Mode logic and the decrypt mux are removed.

## Test plan
- Zero state, encrypt, empty final block (`blk_bytes=0`) → out_data=0, out_last=1 at T+1, x0_o=0x8000000000000000, x1_o..x4_o=0, st_valid pulses for 1 cycle.
- Zero state, encrypt, final block 0xAABBCCDDEEFF0011 with `blk_bytes=3` → out_data=0xAABBCC0000000000, out_bytes=3, x0_o=0xAABBCC8000000000.
- Encrypt full block then empty final block → blk_ready low for exactly 6 cycles after the first handshake, high at T+7. x*_o matches a software p6 model of the state after the first block, with 0x80 pad applied to x0.
- Decrypt (macro on): feed the ciphertext from the previous test with identical initial state → plaintext recovered, and x0_o..x4_o are bit-identical to the encrypt run.
- Assert rst_n low during PERM cycle 3 → all outputs 0 immediately, busy=0. A new start after release runs a clean message.
- Pulse `start` while busy and hold `blk_valid` high in IDLE → state is not reloaded and no block is accepted.

Source files
------------

// File: rtl/ascon_data_process.sv
// ascon_data_process: Ascon-128 message absorb stage with an iterative p6 between blocks.
// Optional decrypt path: define ASCON_DECRYPT_EN (adds the dec port and mode register).
// Ports: clk, rst_n (async, active-low); start with x0_i..x4_i loads the initial state;
//   blk_valid/blk_ready/blk_data/blk_last/blk_bytes carry message blocks;
//   out_valid/out_data/out_bytes/out_last give the registered output block;
//   st_valid with x0_o..x4_o presents the padded final state; busy is high outside IDLE.
module ascon_data_process (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    input  logic        blk_valid,
    output logic        blk_ready,
    input  logic [63:0] blk_data,
    input  logic        blk_last,
    input  logic [2:0]  blk_bytes,
`ifdef ASCON_DECRYPT_EN
    input  logic        dec,
`endif
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic [2:0]  out_bytes,
    output logic        out_last,
    output logic        st_valid,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ABSORB, PERM, DONE} state_t;
    state_t      state_q, state_d;
    logic [3:0]  r_q, r_d;
    logic [63:0] x_q [5];
    logic [63:0] x_d [5];
    logic [63:0] a [5];
    logic [63:0] s [5];
    logic [63:0] b [5];
    logic [63:0] rnd [5];
    logic        out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [63:0] out_data_q, out_data_d;
    logic [2:0]  out_bytes_q, out_bytes_d;
    logic [3:0]  n;
    logic [63:0] mask, pad, x0_enc, x0_abs;

    function automatic logic [63:0] rotr(input logic [63:0] v, input int k);
        return (v >> k) | (v << (64 - k));
    endfunction

    // n = 8 shifts everything out: full mask, no pad
    assign n      = blk_last ? {1'b0, blk_bytes} : 4'd8;
    assign mask   = ~(64'hFFFF_FFFF_FFFF_FFFF >> {n, 3'b000});
    assign pad    = 64'h8000_0000_0000_0000 >> {n, 3'b000};
    assign x0_enc = x_q[0] ^ (blk_data & mask) ^ pad;

`ifdef ASCON_DECRYPT_EN
    logic dec_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dec_q <= 1'b0;
        else if (state_q == IDLE && start) dec_q <= dec;
    // ciphertext overwrites the rate bytes so the state tracks the encrypt side
    assign x0_abs = dec_q ? ((blk_data & mask) | (x_q[0] & ~mask)) ^ pad : x0_enc;
`else
    assign x0_abs = x0_enc;
`endif

    always_comb begin
        a[0] = x_q[0] ^ x_q[4];
        a[1] = x_q[1];
        a[2] = x_q[2] ^ x_q[1] ^ {56'd0, 4'd15 - r_q, r_q};
        a[3] = x_q[3];
        a[4] = x_q[4] ^ x_q[3];
        for (int i = 0; i < 5; i++) s[i] = a[i] ^ (~a[(i + 1) % 5] & a[(i + 2) % 5]);
        b[0] = s[0] ^ s[4];
        b[1] = s[1] ^ s[0];
        b[2] = ~s[2];
        b[3] = s[3] ^ s[2];
        b[4] = s[4];
        rnd[0] = b[0] ^ rotr(b[0], 19) ^ rotr(b[0], 28);
        rnd[1] = b[1] ^ rotr(b[1], 61) ^ rotr(b[1], 39);
        rnd[2] = b[2] ^ rotr(b[2], 1) ^ rotr(b[2], 6);
        rnd[3] = b[3] ^ rotr(b[3], 10) ^ rotr(b[3], 17);
        rnd[4] = b[4] ^ rotr(b[4], 7) ^ rotr(b[4], 41);
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        x_d         = x_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        out_last_d  = out_last_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ABSORB;
                x_d     = '{x0_i, x1_i, x2_i, x3_i, x4_i};
            end
            ABSORB: if (blk_valid) begin
                x_d[0]      = x0_abs;
                out_valid_d = 1'b1;
                out_data_d  = (x_q[0] ^ blk_data) & mask;
                out_bytes_d = n[2:0];
                out_last_d  = blk_last;
                state_d     = blk_last ? DONE : PERM;
                r_d         = 4'd6;
            end
            PERM: begin
                x_d     = rnd;
                r_d     = r_q + 4'd1;
                state_d = r_q == 4'd11 ? ABSORB : PERM;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= 4'd0;
            x_q         <= '{default: '0};
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            out_last_q  <= out_last_d;
        end
    end

    assign blk_ready = state_q == ABSORB;
    assign busy      = state_q != IDLE;
    assign st_valid  = state_q == DONE;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_bytes = out_bytes_q;
    assign out_last  = out_last_q;
    assign x0_o      = x_q[0];
    assign x1_o      = x_q[1];
    assign x2_o      = x_q[2];
    assign x3_o      = x_q[3];
    assign x4_o      = x_q[4];
endmodule

// File: tb/tb_ascon_data_process.sv
// tb_ascon_data_process: directed bench for ascon_data_process (reference p6 model built in)
module tb_ascon_data_process;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] x0_i = '0, x1_i = '0, x2_i = '0, x3_i = '0, x4_i = '0;
    logic        blk_valid = 1'b0;
    logic        blk_ready;
    logic [63:0] blk_data = '0;
    logic        blk_last = 1'b0;
    logic [2:0]  blk_bytes = '0;
`ifdef ASCON_DECRYPT_EN
    logic        dec = 1'b0;
`endif
    logic        out_valid;
    logic [63:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_last;
    logic        st_valid;
    logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] m [5];
    logic [63:0] ct_saved;
    logic [319:0] final_saved;

    localparam logic [63:0] PT = 64'h0123456789ABCDEF;
    localparam logic [63:0] PAD8 = 64'h8000000000000000;

    ascon_data_process dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x0_i(x0_i), .x1_i(x1_i), .x2_i(x2_i), .x3_i(x3_i), .x4_i(x4_i),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_last(blk_last), .blk_bytes(blk_bytes),
`ifdef ASCON_DECRYPT_EN
        .dec(dec),
`endif
        .out_valid(out_valid), .out_data(out_data), .out_bytes(out_bytes), .out_last(out_last),
        .st_valid(st_valid),
        .x0_o(x0_o), .x1_o(x1_o), .x2_o(x2_o), .x3_o(x3_o), .x4_o(x4_o),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] v, input int k);
        return (v >> k) | (v << (64 - k));
    endfunction

    task automatic model_p6();
        logic [7:0]  rc [6] = '{8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
        logic [63:0] t [5];
        for (int i = 0; i < 6; i++) begin
            m[2] = m[2] ^ {56'd0, rc[i]};
            m[0] = m[0] ^ m[4];
            m[4] = m[4] ^ m[3];
            m[2] = m[2] ^ m[1];
            for (int j = 0; j < 5; j++) t[j] = ~m[j] & m[(j + 1) % 5];
            for (int j = 0; j < 5; j++) m[j] = m[j] ^ t[(j + 1) % 5];
            m[1] = m[1] ^ m[0];
            m[0] = m[0] ^ m[4];
            m[3] = m[3] ^ m[2];
            m[2] = ~m[2];
            m[0] = m[0] ^ ror(m[0], 19) ^ ror(m[0], 28);
            m[1] = m[1] ^ ror(m[1], 61) ^ ror(m[1], 39);
            m[2] = m[2] ^ ror(m[2], 1) ^ ror(m[2], 6);
            m[3] = m[3] ^ ror(m[3], 10) ^ ror(m[3], 17);
            m[4] = m[4] ^ ror(m[4], 7) ^ ror(m[4], 41);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [63:0] a0, a1, a2, a3, a4, input logic d);
        x0_i = a0; x1_i = a1; x2_i = a2; x3_i = a3; x4_i = a4;
`ifdef ASCON_DECRYPT_EN
        dec = d;
`else
        if (d) $display("note: decrypt requested without ASCON_DECRYPT_EN");
`endif
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] d, input logic l, input logic [2:0] nb);
        int w = 0;
        blk_valid = 1'b1; blk_data = d; blk_last = l; blk_bytes = nb;
        while (!blk_ready && w < 20) begin
            step();
            w++;
        end
        n_checks++;
        if (blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: blk_ready=%b after %0d cycles, required 1", blk_ready, w);
        end
        step();
        blk_valid = 1'b0; blk_data = '0; blk_last = 1'b0; blk_bytes = '0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_checks++;
        if ({busy, blk_ready, out_valid, out_last, st_valid, out_bytes} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 0", {busy, blk_ready, out_valid, out_last, st_valid, out_bytes});
        end
        n_checks++;
        if ({out_data, x0_o, x1_o, x2_o, x3_o, x4_o} !== 384'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", {out_data, x0_o, x1_o, x2_o, x3_o, x4_o});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_empty_final();
        do_start('0, '0, '0, '0, '0, 1'b0);
        n_checks++;
        if ({busy, blk_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL start_absorb: busy,blk_ready=%b required 11", {busy, blk_ready});
        end
        send_block(64'h1122334455667788, 1'b1, 3'd0);
        n_checks++;
        if ({out_valid, out_last, st_valid, out_bytes, out_data} !== {3'b111, 3'd0, 64'd0}) begin
            n_fail++;
            $display("FAIL empty_out: valid,last,st,bytes,data=%b %b %b %0d %h required 1 1 1 0 0",
                     out_valid, out_last, st_valid, out_bytes, out_data);
        end
        n_checks++;
        if ({x0_o, x1_o, x2_o, x3_o, x4_o} !== {PAD8, 256'd0}) begin
            n_fail++;
            $display("FAIL empty_state: got %h required %h", {x0_o, x1_o, x2_o, x3_o, x4_o}, {PAD8, 256'd0});
        end
        step();
        n_checks++;
        if ({st_valid, out_valid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL empty_after: st,out_valid,busy=%b required 000", {st_valid, out_valid, busy});
        end
    endtask

    task automatic test_partial();
        do_start('0, '0, '0, '0, '0, 1'b0);
        send_block(64'hAABBCCDDEEFF0011, 1'b1, 3'd3);
        n_checks++;
        if ({out_data, out_bytes, out_last, st_valid} !== {64'hAABBCC0000000000, 3'd3, 2'b11}) begin
            n_fail++;
            $display("FAIL partial_out: data=%h bytes=%0d last=%b st=%b required AABBCC0000000000 3 1 1",
                     out_data, out_bytes, out_last, st_valid);
        end
        n_checks++;
        if (x0_o !== 64'hAABBCC8000000000) begin
            n_fail++;
            $display("FAIL partial_x0: got %h required AABBCC8000000000", x0_o);
        end
        step();
    endtask

    task automatic test_full_then_empty();
        int lows = 0;
        m = '{64'h80400C0600000000, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
              64'h1122334455667788, 64'h99AABBCCDDEEFF00};
        do_start(m[0], m[1], m[2], m[3], m[4], 1'b0);
        send_block(PT, 1'b0, 3'd0);
        m[0] = m[0] ^ PT;
        ct_saved = m[0];
        n_checks++;
        if ({out_valid, out_last, out_bytes, out_data} !== {2'b10, 3'd0, ct_saved}) begin
            n_fail++;
            $display("FAIL full_out: valid=%b last=%b bytes=%0d data=%h required 1 0 0 %h",
                     out_valid, out_last, out_bytes, out_data, ct_saved);
        end
        for (int i = 0; i < 6; i++) begin
            if (!blk_ready) lows++;
            step();
        end
        n_checks++;
        if ({lows[3:0], blk_ready, out_valid} !== {4'd6, 2'b10}) begin
            n_fail++;
            $display("FAIL perm_gap: low cycles=%0d ready=%b out_valid=%b required 6 1 0", lows, blk_ready, out_valid);
        end
        model_p6();
        m[0] = m[0] ^ PAD8;
        final_saved = {m[0], m[1], m[2], m[3], m[4]};
        send_block(64'hDEADBEEFDEADBEEF, 1'b1, 3'd0);
        n_checks++;
        if ({out_data, out_last, st_valid} !== {64'd0, 2'b11}) begin
            n_fail++;
            $display("FAIL full_final_out: data=%h last=%b st=%b required 0 1 1", out_data, out_last, st_valid);
        end
        n_checks++;
        if ({x0_o, x1_o, x2_o, x3_o, x4_o} !== final_saved) begin
            n_fail++;
            $display("FAIL full_p6_state: got %h required %h", {x0_o, x1_o, x2_o, x3_o, x4_o}, final_saved);
        end
        step();
    endtask

`ifdef ASCON_DECRYPT_EN
    task automatic test_decrypt();
        do_start(64'h80400C0600000000, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
                 64'h1122334455667788, 64'h99AABBCCDDEEFF00, 1'b1);
        send_block(ct_saved, 1'b0, 3'd0);
        n_checks++;
        if (out_data !== PT) begin
            n_fail++;
            $display("FAIL dec_plain: got %h required %h", out_data, PT);
        end
        send_block(64'hFFFFFFFFFFFFFFFF, 1'b1, 3'd0);
        n_checks++;
        if ({x0_o, x1_o, x2_o, x3_o, x4_o} !== final_saved) begin
            n_fail++;
            $display("FAIL dec_state: got %h required %h", {x0_o, x1_o, x2_o, x3_o, x4_o}, final_saved);
        end
        step();
        dec = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_perm();
        do_start('0, '0, '0, '0, '0, 1'b0);
        send_block(PT, 1'b0, 3'd0);
        step();
        step();
        n_checks++;
        if ({busy, blk_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL perm3_busy: busy,ready=%b required 10", {busy, blk_ready});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, blk_ready, out_valid, out_last, st_valid, out_bytes, out_data, x0_o, x1_o, x2_o, x3_o, x4_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b ready=%b data=%h x=%h required all 0",
                     busy, blk_ready, out_data, {x0_o, x1_o, x2_o, x3_o, x4_o});
        end
        step();
        rst_n = 1'b1;
        step();
        do_start('0, '0, '0, '0, '0, 1'b0);
        send_block(64'h5555555555555555, 1'b1, 3'd0);
        n_checks++;
        if ({x0_o, x1_o, x2_o, x3_o, x4_o, out_last, st_valid} !== {PAD8, 256'd0, 2'b11}) begin
            n_fail++;
            $display("FAIL post_reset_msg: x=%h last=%b st=%b required %h 1 1",
                     {x0_o, x1_o, x2_o, x3_o, x4_o}, out_last, st_valid, {PAD8, 256'd0});
        end
        step();
    endtask

    task automatic test_busy_ignore();
        int hits = 0;
        m = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
        do_start(m[0], m[1], m[2], m[3], m[4], 1'b0);
        x0_i = '1; x1_i = '1; x2_i = '1; x3_i = '1; x4_i = '1;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if ({x0_o, x1_o, x2_o, x3_o, x4_o} !== {64'd1, 64'd2, 64'd3, 64'd4, 64'd5}) begin
            n_fail++;
            $display("FAIL start_in_absorb: x=%h required state 1..5 unchanged", {x0_o, x1_o, x2_o, x3_o, x4_o});
        end
        send_block(64'd0, 1'b0, 3'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        model_p6();
        m[0] = m[0] ^ PAD8;
        send_block(64'h0, 1'b1, 3'd0);
        n_checks++;
        if ({x0_o, x1_o, x2_o, x3_o, x4_o} !== {m[0], m[1], m[2], m[3], m[4]}) begin
            n_fail++;
            $display("FAIL start_in_perm: got %h required %h", {x0_o, x1_o, x2_o, x3_o, x4_o}, {m[0], m[1], m[2], m[3], m[4]});
        end
        step();
        blk_valid = 1'b1;
        blk_data = 64'hCAFEF00DCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            if (blk_ready || out_valid) hits++;
            step();
        end
        blk_valid = 1'b0;
        n_checks++;
        if ({hits[3:0], busy} !== 5'd0) begin
            n_fail++;
            $display("FAIL idle_valid: accepted=%0d busy=%b required 0 0", hits, busy);
        end
        n_checks++;
        if ({x0_o, x1_o, x2_o, x3_o, x4_o} !== {m[0], m[1], m[2], m[3], m[4]}) begin
            n_fail++;
            $display("FAIL idle_hold: got %h required %h", {x0_o, x1_o, x2_o, x3_o, x4_o}, {m[0], m[1], m[2], m[3], m[4]});
        end
    endtask

    initial begin
        test_reset();
        test_empty_final();
        test_partial();
        test_full_then_empty();
`ifdef ASCON_DECRYPT_EN
        test_decrypt();
`endif
        test_reset_mid_perm();
        test_busy_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
